// File: rtl/roce_rnr_retry_timer_if.sv
// Handshake bundle between the ACK/NAK parser, the RNR back-off engine and the retransmit logic.
// The master side drives the NAK/ACK strobes and the retransmit ready.
interface roce_rnr_retry_timer_if #(
  parameter int PSN_WIDTH = 24
) ();
  logic                 s_rnr_nak_valid;
  logic [4:0]           s_rnr_nak_timer;
  logic [PSN_WIDTH-1:0] s_rnr_nak_psn;
  logic                 s_ack_valid;
  logic                 m_retrans_valid;
  logic [PSN_WIDTH-1:0] m_retrans_psn;
  logic                 m_retrans_ready;

  modport master (
    output s_rnr_nak_valid, s_rnr_nak_timer, s_rnr_nak_psn, s_ack_valid, m_retrans_ready,
    input  m_retrans_valid, m_retrans_psn
  );

  modport slave (
    input  s_rnr_nak_valid, s_rnr_nak_timer, s_rnr_nak_psn, s_ack_valid, m_retrans_ready,
    output m_retrans_valid, m_retrans_psn
  );
endinterface

// File: rtl/roce_rnr_retry_timer.sv
// Per-QP RNR NAK back-off engine: pauses TX for the IB RNR delay, then asks for a retransmit
// from the NAKed PSN, and raises a sticky error once the QP rnr_retry budget is used up.
module roce_rnr_retry_timer #(
  parameter int PSN_WIDTH           = 24,
  parameter int TIMER_WIDTH         = 32,
  parameter int TIMER_SCALE_SHIFT   = 0,
  parameter int NET_CLOCK_PERIOD_PS = 4000
) (
  input  logic                   clk,
  input  logic                   rst,
  roce_rnr_retry_timer_if.slave  bus,
  input  logic                   cfg_qp_active,
  input  logic [2:0]             cfg_rnr_retry,
  output logic                   tx_pause,
  output logic                   rnr_retry_exceeded,
  output logic [TIMER_WIDTH-1:0] status_timer_remaining,
  output logic [2:0]             status_retry_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // IB RNR NAK timer table, in units of 10 us (code 0 is the 655.36 ms maximum).
  function automatic logic [31:0] rnr_units_10us(input logic [4:0] code);
    logic [31:0] u;
    case (code)
      5'd0:    u = 32'd65536;
      5'd1:    u = 32'd1;
      5'd2:    u = 32'd2;
      5'd3:    u = 32'd3;
      5'd4:    u = 32'd4;
      5'd5:    u = 32'd6;
      5'd6:    u = 32'd8;
      5'd7:    u = 32'd12;
      5'd8:    u = 32'd16;
      5'd9:    u = 32'd24;
      5'd10:   u = 32'd32;
      5'd11:   u = 32'd48;
      5'd12:   u = 32'd64;
      5'd13:   u = 32'd96;
      5'd14:   u = 32'd128;
      5'd15:   u = 32'd192;
      5'd16:   u = 32'd256;
      5'd17:   u = 32'd384;
      5'd18:   u = 32'd512;
      5'd19:   u = 32'd768;
      5'd20:   u = 32'd1024;
      5'd21:   u = 32'd1536;
      5'd22:   u = 32'd2048;
      5'd23:   u = 32'd3072;
      5'd24:   u = 32'd4096;
      5'd25:   u = 32'd6144;
      5'd26:   u = 32'd8192;
      5'd27:   u = 32'd12288;
      5'd28:   u = 32'd16384;
      5'd29:   u = 32'd24576;
      5'd30:   u = 32'd32768;
      5'd31:   u = 32'd49152;
      default: u = 32'd1;
    endcase
    return u;
  endfunction

  // Delays are converted to clocks at elaboration so no divider is built; a zero delay becomes 1.
  function automatic logic [32*TIMER_WIDTH-1:0] build_delay_lut();
    logic [32*TIMER_WIDTH-1:0] lut;
    logic [63:0]               clocks;
    lut = '0;
    for (int i = 0; i < 32; i++) begin
      clocks = (64'(rnr_units_10us(5'(i))) * 64'd10000000 / 64'(NET_CLOCK_PERIOD_PS))
               >> TIMER_SCALE_SHIFT;
      if (clocks == 64'd0) begin
        clocks = 64'd1;
      end else begin
        clocks = clocks;
      end
      lut[i*TIMER_WIDTH +: TIMER_WIDTH] = TIMER_WIDTH'(clocks);
    end
    return lut;
  endfunction

  localparam logic [32*TIMER_WIDTH-1:0] DELAY_LUT = build_delay_lut();

  state_e                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [2:0]             retry_cnt_q, retry_cnt_d;
  logic [PSN_WIDTH-1:0]   psn_q, psn_d;
  logic                   tx_pause_q, tx_pause_d;
  logic                   retrans_valid_q, retrans_valid_d;
  logic [PSN_WIDTH-1:0]   retrans_psn_q, retrans_psn_d;
  logic                   exceeded_q, exceeded_d;
  logic [TIMER_WIDTH-1:0] nak_delay_s;

  assign nak_delay_s = DELAY_LUT[32'(bus.s_rnr_nak_timer) * TIMER_WIDTH +: TIMER_WIDTH];

  // Next-state, counter and output computation; a closed QP overrides every state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_cnt_d = retry_cnt_q;
    psn_d       = psn_q;
    if (!cfg_qp_active) begin
      state_d     = ST_IDLE;
      timer_d     = '0;
      retry_cnt_d = 3'd0;
      psn_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.s_rnr_nak_valid) begin
            if ((cfg_rnr_retry != 3'd7) && (retry_cnt_q == cfg_rnr_retry)) begin
              state_d = ST_ERROR;
            end else begin
              state_d     = ST_WAIT;
              timer_d     = nak_delay_s;
              psn_d       = bus.s_rnr_nak_psn;
              retry_cnt_d = (retry_cnt_q == 3'd7) ? 3'd7 : retry_cnt_q + 3'd1;
            end
          end else if (bus.s_ack_valid) begin
            retry_cnt_d = 3'd0;
          end else begin
            retry_cnt_d = retry_cnt_q;
          end
        end
        ST_WAIT: begin
          // Duplicate NAKs are ignored here: the running delay is never reloaded.
          if (bus.s_ack_valid) begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            retry_cnt_d = 3'd0;
          end else if (timer_q <= TIMER_WIDTH'(1)) begin
            state_d = ST_ISSUE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TIMER_WIDTH'(1);
          end
        end
        ST_ISSUE: begin
          if (bus.m_retrans_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
    tx_pause_d      = (state_d != ST_IDLE);
    retrans_valid_d = (state_d == ST_ISSUE);
    retrans_psn_d   = (state_d == ST_ISSUE) ? psn_d : '0;
    exceeded_d      = (state_d == ST_ERROR);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      retry_cnt_q     <= 3'd0;
      psn_q           <= '0;
      tx_pause_q      <= 1'b0;
      retrans_valid_q <= 1'b0;
      retrans_psn_q   <= '0;
      exceeded_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      retry_cnt_q     <= retry_cnt_d;
      psn_q           <= psn_d;
      tx_pause_q      <= tx_pause_d;
      retrans_valid_q <= retrans_valid_d;
      retrans_psn_q   <= retrans_psn_d;
      exceeded_q      <= exceeded_d;
    end
  end

  assign bus.m_retrans_valid     = retrans_valid_q;
  assign bus.m_retrans_psn       = retrans_psn_q;
  assign tx_pause                = tx_pause_q;
  assign rnr_retry_exceeded      = exceeded_q;
  assign status_timer_remaining  = timer_q;
  assign status_retry_cnt        = retry_cnt_q;

endmodule

// File: tb/tb_roce_rnr_retry_timer.sv
// Self-checking bench for roce_rnr_retry_timer: vector table, directed corner sequences and
// random traffic compared every cycle against a deadline-based reference model.
module tb_roce_rnr_retry_timer;
  localparam int SHIFT     = 8;
  localparam int PERIOD_PS = 4000;

  logic        clk = 1'b0;
  logic        rst, qp;
  logic [2:0]  lim;
  logic        pause, exc;
  logic [31:0] trem;
  logic [2:0]  rcnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: mode 0 idle, 1 waiting, 2 requesting, 3 error; expiry kept as a deadline.
  int          m_mode, m_cnt, m_dead;
  logic [23:0] m_psn;

  int unit_tab [32] = '{65536, 1, 2, 3, 4, 6, 8, 12, 16, 24, 32, 48, 64, 96, 128, 192,
                        256, 384, 512, 768, 1024, 1536, 2048, 3072, 4096, 6144, 8192,
                        12288, 16384, 24576, 32768, 49152};

  roce_rnr_retry_timer_if #(.PSN_WIDTH(24)) bus ();

  roce_rnr_retry_timer #(
    .PSN_WIDTH(24), .TIMER_WIDTH(32), .TIMER_SCALE_SHIFT(SHIFT), .NET_CLOCK_PERIOD_PS(PERIOD_PS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .cfg_qp_active(qp), .cfg_rnr_retry(lim),
    .tx_pause(pause), .rnr_retry_exceeded(exc),
    .status_timer_remaining(trem), .status_retry_cnt(rcnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int delay_n(input int code);
    longint c;
    c = (longint'(unit_tab[code]) * 64'd10000000 / PERIOD_PS) >> SHIFT;
    return (c == 0) ? 1 : int'(c);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    if (rst || !qp) begin
      m_mode = 0; m_cnt = 0; m_psn = 24'd0;
    end else begin
      case (m_mode)
        0: if (bus.s_rnr_nak_valid) begin
             if (lim != 3'd7 && m_cnt == int'(lim)) m_mode = 3;
             else begin
               m_psn  = bus.s_rnr_nak_psn;
               m_cnt  = (m_cnt < 7) ? m_cnt + 1 : 7;
               m_dead = cyc + delay_n(int'(bus.s_rnr_nak_timer));
               m_mode = 1;
             end
           end else if (bus.s_ack_valid) m_cnt = 0;
        1: if (bus.s_ack_valid) begin m_mode = 0; m_cnt = 0; end
           else if (cyc >= m_dead) m_mode = 2;
        2: if (bus.m_retrans_ready) m_mode = 0;
        default: ;
      endcase
    end
  endtask

  // One clock: advance the model, sample after the edge, compare, clear the strobes.
  task automatic tick();
    logic [61:0] act, exp;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    act = {pause, bus.m_retrans_valid, bus.m_retrans_psn, exc, trem, rcnt};
    exp = {1'(m_mode != 0), 1'(m_mode == 2), (m_mode == 2) ? m_psn : 24'd0, 1'(m_mode == 3),
           (m_mode == 1) ? 32'(m_dead - cyc + 1) : 32'd0, 3'(m_cnt)};
    check("model", 64'(act), 64'(exp));
    bus.s_rnr_nak_valid = 1'b0;
    bus.s_ack_valid     = 1'b0;
  endtask

  task automatic nak(input int code, input logic [23:0] psn);
    bus.s_rnr_nak_valid = 1'b1;
    bus.s_rnr_nak_timer = 5'(code);
    bus.s_rnr_nak_psn   = psn;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.m_retrans_valid && n < 200) begin tick(); n++; end
    check(name, 64'(bus.m_retrans_valid), 64'd1);
  endtask

  task automatic handshake();
    bus.m_retrans_ready = 1'b1;
    tick();
    bus.m_retrans_ready = 1'b0;
  endtask

  typedef struct {
    logic        rst, qp;
    logic [2:0]  lim;
    logic        nak, ack;
    logic [4:0]  code;
    logic        e_pause, e_valid, e_exc;
    logic [2:0]  e_cnt;
    logic [31:0] e_timer;
  } vec_t;

  vec_t vt [12];

  initial begin
    int n;
    logic lost, seen;
    vt[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0};
    vt[1]  = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 3'd0, 32'd0};
    vt[2]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 3'd0, 32'd0};
    vt[3]  = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 3'd0, 32'd0};
    vt[4]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0};
    vt[5]  = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0};
    vt[6]  = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd9};
    vt[7]  = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd8};
    vt[8]  = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd1, 32'd7};
    vt[9]  = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0};
    vt[10] = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd9};
    vt[11] = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0};

    rst = 1'b1; qp = 1'b0; lim = 3'd0;
    bus.s_rnr_nak_valid = 1'b0; bus.s_rnr_nak_timer = 5'd0; bus.s_rnr_nak_psn = 24'd0;
    bus.s_ack_valid = 1'b0; bus.m_retrans_ready = 1'b0;
    m_mode = 0; m_cnt = 0; m_dead = 0; m_psn = 24'd0;

    for (int i = 0; i < 12; i++) begin
      rst = vt[i].rst; qp = vt[i].qp; lim = vt[i].lim;
      bus.s_rnr_nak_valid = vt[i].nak; bus.s_ack_valid = vt[i].ack;
      bus.s_rnr_nak_timer = vt[i].code; bus.s_rnr_nak_psn = 24'hABC;
      tick();
      check($sformatf("vec%0d", i), 64'({pause, bus.m_retrans_valid, exc, rcnt, trem}),
            64'({vt[i].e_pause, vt[i].e_valid, vt[i].e_exc, vt[i].e_cnt, vt[i].e_timer}));
    end
    rst = 1'b0;

    // Latency from NAK to first retransmit request, with TX paused throughout.
    lim = 3'd3;
    nak(1, 24'h000123); tick(); n = 1; lost = 1'b0;
    while (!bus.m_retrans_valid && n < 200) begin
      if (!pause) lost = 1'b1;
      tick(); n++;
    end
    check("t1_latency", 64'(n), 64'(delay_n(1) + 1));
    check("t1_psn", 64'(bus.m_retrans_psn), 64'h123);
    check("t1_pause", 64'(lost), 64'd0);

    // Back-pressure in the request phase, then release.
    repeat (5) begin
      tick();
      check("t2_hold", 64'({bus.m_retrans_valid, bus.m_retrans_psn}), 64'({1'b1, 24'h000123}));
    end
    handshake();
    check("t2_release", 64'({bus.m_retrans_valid, pause}), 64'd0);
    check("t2_cnt", 64'(rcnt), 64'd1);

    // Retry budget of two: third NAK goes to error with no further request.
    qp = 1'b0; tick(); qp = 1'b1; lim = 3'd2;
    for (int k = 0; k < 2; k++) begin
      nak(2, 24'(k + 16)); tick(); wait_valid("t3_valid"); handshake();
    end
    nak(1, 24'h000777); tick();
    check("t3_err", 64'({exc, pause}), 64'b11);
    seen = 1'b0;
    repeat (30) begin tick(); if (bus.m_retrans_valid) seen = 1'b1; end
    check("t3_noretx", 64'(seen), 64'd0);
    qp = 1'b0; tick();
    check("t3_clear", 64'({exc, rcnt, pause}), 64'd0);
    qp = 1'b1;

    // Infinite retries: count saturates at seven and never errors.
    lim = 3'd7;
    for (int k = 0; k < 10; k++) begin
      nak(1, 24'(k)); tick(); wait_valid("t4_valid"); handshake();
      check("t4_noerr", 64'(exc), 64'd0);
    end
    check("t4_sat", 64'(rcnt), 64'd7);

    // ACK in the middle of the wait cancels the retransmit.
    nak(1, 24'h000042); tick(); repeat (3) tick();
    bus.s_ack_valid = 1'b1; tick();
    check("t5_ack", 64'({pause, bus.m_retrans_valid, rcnt}), 64'd0);
    seen = 1'b0;
    repeat (20) begin tick(); if (bus.m_retrans_valid) seen = 1'b1; end
    check("t5_noretx", 64'(seen), 64'd0);

    // A duplicate NAK while waiting must not restart the delay.
    nak(1, 24'h000055); tick(); n = 1;
    repeat (3) begin tick(); n++; end
    nak(5, 24'h000066); tick(); n++;
    while (!bus.m_retrans_valid && n < 200) begin tick(); n++; end
    check("t5_dup_latency", 64'(n), 64'(delay_n(1) + 1));
    check("t5_dup_psn", 64'(bus.m_retrans_psn), 64'h55);
    handshake();

    // Closing the QP drops a pending request; reset mid-wait clears everything.
    nak(1, 24'h000099); tick(); wait_valid("t6_valid");
    qp = 1'b0; tick();
    check("t6_qpdown", 64'({bus.m_retrans_valid, pause}), 64'd0);
    qp = 1'b1;
    nak(3, 24'h0000AA); tick(); repeat (3) tick();
    rst = 1'b1; tick();
    check("t6_rst", 64'({pause, bus.m_retrans_valid, bus.m_retrans_psn, exc, trem, rcnt}), 64'd0);
    rst = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      qp  = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 199) == 0) lim = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 11) == 0) nak($urandom_range(1, 6), 24'($urandom));
      bus.s_ack_valid     = ($urandom_range(0, 24) == 0);
      bus.m_retrans_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
